fm_op_seq: RTL and testbench

// Operator-slot sequencer for the FM synth envelope/operator pipeline. Time-multiplexes
// one shared per-operator datapath (envelope generator plus its op-data RAM) across all

---
 rtl/fm_pkg.sv | 23 ++
 rtl/fm_kon_track.sv | 48 ++++
 rtl/fm_op_seq.sv | 112 +++++++++++
 tb/tb_fm_op_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared constants, state encodings and helpers for the FM operator pipeline
package fm_pkg;

    localparam int FM_NUM_OPS     = 36;
    localparam int FM_NUM_CH      = 18;
    localparam int FM_SLOT_CYCLES = 4;

    localparam int FM_OP_W = $clog2(FM_NUM_OPS);
    localparam int FM_CH_W = $clog2(FM_NUM_CH);
    localparam int FM_PH_W = $clog2(FM_SLOT_CYCLES);

    typedef enum logic [1:0] {
        SEQ_INIT = 2'd0,
        SEQ_IDLE = 2'd1,
        SEQ_RUN  = 2'd2
    } seq_state_e;

    // Two operators share a channel; the low op bit selects which one.
    function automatic logic [FM_CH_W-1:0] op_to_ch(input logic [FM_OP_W-1:0] op);
        return op[FM_OP_W-1:1];
    endfunction

endpackage

// File: rtl/fm_kon_track.sv
// rtl/fm_kon_track.sv - per-channel key-on latch and edge detector for the operator sweep
module fm_kon_track
    import fm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               capture_i,
    input  logic               commit_i,
    input  logic               active_i,
    input  logic [FM_CH_W-1:0] ch_i,
    input  logic [FM_NUM_CH-1:0] kon_vec_i,
    output logic               kon_o,
    output logic               restart_o
);

    logic [FM_NUM_CH-1:0] kon_lat_q, kon_lat_d;
    logic [FM_NUM_CH-1:0] kon_prev_q, kon_prev_d;

    // Snapshot key-on once per sweep; remember it per channel after the channel's second op.
    always_comb begin
        kon_lat_d  = kon_lat_q;
        kon_prev_d = kon_prev_q;
        if (capture_i) begin
            kon_lat_d = kon_vec_i;
        end
        if (commit_i) begin
            kon_prev_d[ch_i] = kon_lat_q[ch_i];
        end
    end

    // Latch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            kon_lat_q  <= '0;
            kon_prev_q <= '0;
        end else begin
            kon_lat_q  <= kon_lat_d;
            kon_prev_q <= kon_prev_d;
        end
    end

    // Outputs are only meaningful during a sample sweep; forced low otherwise.
    always_comb begin
        kon_o     = active_i & kon_lat_q[ch_i];
        restart_o = active_i & kon_lat_q[ch_i] & ~kon_prev_q[ch_i];
    end

endmodule

// File: rtl/fm_op_seq.sv
// rtl/fm_op_seq.sv - operator-slot sequencer with power-up clear sweep and sample sweeps
module fm_op_seq
    import fm_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic [FM_NUM_CH-1:0] kon_vec,
    output logic [FM_OP_W-1:0]   op_sel,
    output logic                 next,
    output logic                 op_reset,
    output logic                 restart,
    output logic                 kon,
    output logic                 busy,
    output logic                 sample_done,
    output logic                 overrun
);

    seq_state_e         state_q, state_d;
    logic [FM_PH_W-1:0] phase_q, phase_d;
    logic [FM_OP_W-1:0] op_sel_q, op_sel_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic               sample_done_q, sample_done_d;

    logic sweeping, last_phase, last_op, slot_end, go;

    assign sweeping   = (state_q != SEQ_IDLE);
    assign last_phase = (phase_q == FM_PH_W'(FM_SLOT_CYCLES - 1));
    assign last_op    = (op_sel_q == FM_OP_W'(FM_NUM_OPS - 1));
    assign slot_end   = sweeping & last_phase;
    assign go         = (state_q == SEQ_IDLE) & (sample_tick | pending_q);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SEQ_INIT;
            phase_q       <= '0;
            op_sel_q      <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            sample_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            op_sel_q      <= op_sel_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            sample_done_q <= sample_done_d;
        end
    end

    // Next state: sweeps end after the write strobe of the last operator.
    always_comb begin
        state_d       = state_q;
        phase_d       = '0;
        op_sel_d      = '0;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        sample_done_d = (state_q == SEQ_RUN) & slot_end & last_op;

        case (state_q)
            SEQ_INIT: if (slot_end && last_op) state_d = SEQ_IDLE;
            SEQ_IDLE: if (go)                  state_d = SEQ_RUN;
            SEQ_RUN:  if (slot_end && last_op) state_d = SEQ_IDLE;
            default:                           state_d = SEQ_INIT;
        endcase

        if (sweeping) begin
            if (last_phase) begin
                op_sel_d = last_op ? '0 : op_sel_q + FM_OP_W'(1);
            end else begin
                phase_d  = phase_q + FM_PH_W'(1);
                op_sel_d = op_sel_q;
            end
        end

        // A tick while busy is parked in pending; a second one is dropped and flagged.
        // In idle, pending is consumed, but a tick in that same cycle re-arms it.
        if (sweeping) begin
            if (sample_tick) begin
                if (pending_q) overrun_d = 1'b1;
                else           pending_d = 1'b1;
            end
        end else begin
            pending_d = pending_q & sample_tick;
        end
    end

    // Slot-level outputs decoded from state and counters.
    always_comb begin
        op_sel      = op_sel_q;
        next        = slot_end;
        op_reset    = (state_q == SEQ_INIT);
        busy        = sweeping;
        sample_done = sample_done_q;
        overrun     = overrun_q;
    end

    fm_kon_track u_kon_track (
        .clk       (clk),
        .reset     (reset),
        .capture_i (go),
        .commit_i  ((state_q == SEQ_RUN) & slot_end & op_sel_q[0]),
        .active_i  (state_q == SEQ_RUN),
        .ch_i      (op_to_ch(op_sel_q)),
        .kon_vec_i (kon_vec),
        .kon_o     (kon),
        .restart_o (restart)
    );

endmodule

// File: tb/tb_fm_op_seq.sv
// tb/tb_fm_op_seq.sv - scoreboard testbench for fm_op_seq
module tb_fm_op_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic [17:0] kon_vec;
    logic [5:0]  op_sel;
    logic        next, op_reset, restart, kon, busy, sample_done, overrun;

    typedef struct {
        int op;
        int opr;
        int kon;
        int rst;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [17:0] prev_model;

    always #5 clk = ~clk;

    fm_op_seq dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .kon_vec     (kon_vec),
        .op_sel      (op_sel),
        .next        (next),
        .op_reset    (op_reset),
        .restart     (restart),
        .kon         (kon),
        .busy        (busy),
        .sample_done (sample_done),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_sweep(input bit init, input logic [17:0] konv, input logic [17:0] prv);
        exp_t e;
        for (int op = 0; op < 36; op++) begin
            e.op  = op;
            e.opr = init ? 1 : 0;
            e.kon = init ? 0 : int'(konv[op >> 1]);
            e.rst = init ? 0 : int'(konv[op >> 1] & ~prv[op >> 1]);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sample_done) return;
        end
        chk("timeout_sample_done", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        chk("timeout_idle", 0, 1);
    endtask

    task automatic run_sweep();
        push_sweep(1'b0, kon_vec, prev_model);
        prev_model = kon_vec;
        pulse_tick();
        wait_done();
        @(negedge clk);
    endtask

    // Monitor: every write strobe closes a slot; compare it against the oldest expectation.
    always @(negedge clk) begin
        if (next) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_next_op_sel", int'(op_sel), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("slot_op_sel",   int'(op_sel),   e.op);
                chk("slot_op_reset", int'(op_reset), e.opr);
                chk("slot_kon",      int'(kon),      e.kon);
                chk("slot_restart",  int'(restart),  e.rst);
            end
        end
    end

    initial begin
        int n, sd;
        reset       = 1'b1;
        sample_tick = 1'b0;
        kon_vec     = '0;
        prev_model  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", int'(busy), 1);
        chk("rst_op_reset", int'(op_reset), 1);
        chk("rst_next", int'(next), 0);
        chk("rst_op_sel", int'(op_sel), 0);
        chk("rst_sample_done", int'(sample_done), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_kon", int'(kon), 0);
        chk("rst_restart", int'(restart), 0);

        // Init sweep: 144 busy cycles, 36 cleared slots, no sample_done
        push_sweep(1'b1, '0, '0);
        reset = 1'b0;
        n = 0;
        sd = 0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            n++;
            if (sample_done) sd++;
            @(negedge clk);
        end
        chk("init_busy_cycles", n, 144);
        repeat (3) begin
            if (sample_done) sd++;
            @(negedge clk);
        end
        chk("init_no_sample_done", sd, 0);
        chk("init_queue_drained", exp_q.size(), 0);
        chk("init_op_sel_idle", int'(op_sel), 0);

        // Channel 3 key-on: first sweep restarts ops 6/7, second does not
        kon_vec = 18'h00008;
        run_sweep();
        run_sweep();

        // Key-off then key-on again
        kon_vec = 18'h00000;
        run_sweep();
        kon_vec = 18'h00008;
        run_sweep();

        // Tick mid-sweep is deferred and served right after sample_done
        push_sweep(1'b0, kon_vec, prev_model);
        push_sweep(1'b0, kon_vec, kon_vec);
        prev_model = kon_vec;
        pulse_tick();
        repeat (9) @(negedge clk);
        pulse_tick();
        wait_done();
        chk("pend_busy_at_done", int'(busy), 0);
        @(negedge clk);
        chk("pend_busy_after_done", int'(busy), 1);
        chk("pend_op_sel_start", int'(op_sel), 0);
        wait_done();
        @(negedge clk);
        chk("pend_overrun_clear", int'(overrun), 0);
        chk("pend_queue_drained", exp_q.size(), 0);

        // Two extra ticks in one sweep: overrun, only one extra sweep
        push_sweep(1'b0, kon_vec, prev_model);
        push_sweep(1'b0, kon_vec, kon_vec);
        pulse_tick();
        repeat (5) @(negedge clk);
        pulse_tick();
        repeat (5) @(negedge clk);
        pulse_tick();
        chk("ovr_set", int'(overrun), 1);
        wait_done();
        wait_done();
        sd = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sample_done) sd++;
        end
        chk("ovr_no_third_sweep", sd, 0);
        chk("ovr_idle", int'(busy), 0);
        chk("ovr_sticky", int'(overrun), 1);
        chk("ovr_queue_drained", exp_q.size(), 0);

        // Reset at op 20, phase 2 restarts the clear sweep and clears key-on history
        push_sweep(1'b0, kon_vec, prev_model);
        pulse_tick();
        n = 0;
        while (op_sel != 6'd20 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach_op20", int'(op_sel), 20);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        push_sweep(1'b1, '0, '0);
        prev_model = '0;
        @(negedge clk);
        chk("mid_rst_op_sel", int'(op_sel), 0);
        chk("mid_rst_op_reset", int'(op_reset), 1);
        chk("mid_rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        @(negedge clk);
        wait_idle();
        chk("mid_init_drained", exp_q.size(), 0);
        run_sweep();

        chk("final_queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
